// File: rtl/vga_pkg.sv
// Shared VGA drawing types: screen geometry, pixel field widths and the
// draw arbiter state encoding.
package vga_pkg;

  localparam int unsigned SCREEN_W = 160;
  localparam int unsigned SCREEN_H = 120;
  localparam int unsigned COLOUR_W = 3;
  localparam int unsigned X_W      = 8;
  localparam int unsigned Y_W      = 7;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DRAW = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Box origin and colour captured at grant time
  typedef struct packed {
    logic [X_W-1:0]      x;
    logic [Y_W-1:0]      y;
    logic [COLOUR_W-1:0] colour;
  } box_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin pick: a lone request wins, a tie goes to the index
// that did not win last time.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] win,
  output logic       win_idx
);

  always_comb begin
    win_idx = 1'b0;
    win     = 2'b00;
    case (req)
      2'b01:   win_idx = 1'b0;
      2'b10:   win_idx = 1'b1;
      2'b11:   win_idx = ~last;
      default: win_idx = 1'b0;
    endcase
    if (|req) win = win_idx ? 2'b10 : 2'b01;
  end

endmodule

// File: rtl/draw_arbiter.sv
// Shares the VGA pixel-write port between two box-drawing requesters,
// sweeping the granted SIZE x SIZE box one pixel per cycle with screen clipping.
module draw_arbiter
  import vga_pkg::*;
#(
  parameter int unsigned SIZE = 4,
  parameter int unsigned XMAX = SCREEN_W - 1,
  parameter int unsigned YMAX = SCREEN_H - 1
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic [1:0]          req,
  input  logic [X_W-1:0]      x0,
  input  logic [X_W-1:0]      x1,
  input  logic [Y_W-1:0]      y0,
  input  logic [Y_W-1:0]      y1,
  input  logic [COLOUR_W-1:0] c0,
  input  logic [COLOUR_W-1:0] c1,
  output logic [1:0]          grant,
  output logic [1:0]          done,
  output logic                busy,
  output logic [X_W-1:0]      x,
  output logic [Y_W-1:0]      y,
  output logic [COLOUR_W-1:0] colour,
  output logic                plot,
  output logic [1:0]          curr
);

  localparam int unsigned CW = (SIZE > 1) ? $clog2(SIZE) : 1;

  state_t        state, state_n;
  logic [1:0]    grant_n, done_n;
  logic          last, last_n;
  box_t          base, base_n;
  logic [CW-1:0] cx, cx_n, cy, cy_n;
  logic [X_W:0]  xs;
  logic [Y_W:0]  ys;
  logic          plot_n;
  logic [1:0]    win;
  logic          win_idx;

  rr_arb2 u_arb (
    .req     (req),
    .last    (last),
    .win     (win),
    .win_idx (win_idx)
  );

  // State register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= S_IDLE;
    else         state <= state_n;
  end

  // Next state, sweep counters and the pixel to present next cycle
  always_comb begin
    state_n = state;
    grant_n = grant;
    last_n  = last;
    base_n  = base;
    cx_n    = cx;
    cy_n    = cy;
    done_n  = 2'b00;
    case (state)
      S_IDLE: begin
        grant_n = 2'b00;
        if (|req) begin
          grant_n = win;
          last_n  = win_idx;
          base_n  = win_idx ? {x1, y1, c1} : {x0, y0, c0};
          cx_n    = '0;
          cy_n    = '0;
          state_n = S_DRAW;
        end
      end
      S_DRAW: begin
        if (cx == CW'(SIZE - 1)) begin
          cx_n = '0;
          if (cy == CW'(SIZE - 1)) begin
            cy_n    = '0;
            done_n  = grant;
            state_n = S_DONE;
          end else begin
            cy_n = cy + 1'b1;
          end
        end else begin
          cx_n = cx + 1'b1;
        end
      end
      S_DONE: begin
        grant_n = 2'b00;
        state_n = S_IDLE;
      end
      default: begin
        grant_n = 2'b00;
        state_n = S_IDLE;
      end
    endcase

    // Sums are one bit wider so off-screen pixels can be detected and clipped
    xs     = (X_W + 1)'(base_n.x) + (X_W + 1)'(cx_n);
    ys     = (Y_W + 1)'(base_n.y) + (Y_W + 1)'(cy_n);
    plot_n = (state_n == S_DRAW) && (xs <= (X_W + 1)'(XMAX)) && (ys <= (Y_W + 1)'(YMAX));
  end

  // Datapath and registered adapter-facing outputs
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      grant  <= 2'b00;
      done   <= 2'b00;
      busy   <= 1'b0;
      last   <= 1'b1;
      base   <= '0;
      cx     <= '0;
      cy     <= '0;
      x      <= '0;
      y      <= '0;
      colour <= '0;
      plot   <= 1'b0;
    end else begin
      grant  <= grant_n;
      done   <= done_n;
      busy   <= (state_n != S_IDLE);
      last   <= last_n;
      base   <= base_n;
      cx     <= cx_n;
      cy     <= cy_n;
      x      <= xs[X_W-1:0];
      y      <= ys[Y_W-1:0];
      colour <= base_n.colour;
      plot   <= plot_n;
    end
  end

  assign curr = state;

endmodule

// File: doc/draw_arbiter.md
# draw_arbiter

Shares the single VGA pixel-write port between two drawing requesters, for example an "erase old position" engine and a "draw new position" engine. It grants one requester at a time with round-robin priority. For the granted request it sweeps a SIZE×SIZE box in raster order at one pixel per cycle, driving `x`/`y`/`colour`/`plot` straight into the VGA adapter. Pixels outside the 160×120 screen are clipped. It sits between the game-level FSMs and the adapter, replacing the ad-hoc sharing of `wren`/`x`/`y`.

## Interface
- `SIZE`, 4, box edge length in pixels (1..16).
- `XMAX`, 159, last valid x coordinate.
- `YMAX`, 119, last valid y coordinate.

Ports:
- `clk`  in  1  system clock (CLOCK_50 domain).
- `resetn`  in  1  asynchronous reset, active-low.
- `req`  in  2  request per requester; held high until matching `done`.
- `x0`, `x1`  in  8 each  box base x for requester 0 / 1.
- `y0`, `y1`  in  7 each  box base y.
- `c0`, `c1`  in  3 each  box colour.
- `grant`  out  2  one-hot; the requester currently being served.
- `done`  out  2  one-cycle pulse to the served requester when its box is complete.
- `busy`  out  1  high in DRAW or DONE.
- `x`  out  8  pixel x to the adapter.
- `y`  out  7  pixel y to the adapter.
- `colour`  out  3  pixel colour to the adapter.
- `plot`  out  1  pixel write enable to the adapter.
- `curr`  out  2  state encoding, for LEDR debug.

## Operation
- States: IDLE (0), DRAW (1), DONE (2). Encoding 3 is unreachable and returns to IDLE.
- **IDLE:**
  - If any `req` bit is high, pick the winner, set `grant`, and latch its x/y/c into base registers.
  - Clear counters `cx`, `cy` and go to DRAW.
  - If no request, stay in IDLE.
- **Arbitration:**
  - Pointer `last` holds the index of the previous winner.
  - If one request is pending, it wins.
  - If both are pending, the index ≠ `last` wins.
  - `last` updates on each grant.
- **DRAW:**
  - `x = bx + cx` and `y = by + cy`, using the low 8/7 bits of a 9/8-bit sum.
  - `colour` = latched colour.
  - `plot` = 1 only if the 9-bit x sum ≤ `XMAX` and the 8-bit y sum ≤ `YMAX`.
  - `cx` increments every cycle. When `cx` = SIZE-1 it wraps to 0 and `cy` increments.
  - When `cx` = `cy` = SIZE-1, go to DONE.
  - Clipped pixels still consume their cycle with `plot` = 0.
- **DONE:**
  - `done[grantee]` = 1 for one cycle, `grant` is held, `plot` = 0.
  - Next state is IDLE, where `grant` clears.
- Inputs are sampled only at grant. Changes to `x*`/`y*`/`c*`/`req` during DRAW are ignored, and the box always completes.
- A requester that keeps `req` high after `done` is treated as a new request and is subject to round-robin.

## Timing
- Reset values:
  - State IDLE.
  - `grant` = 0, `done` = 0, `busy` = 0, `plot` = 0.
  - `x` = 0, `y` = 0, `colour` = 0, `curr` = 0.
  - `last` = 1, so requester 0 wins the first tie.
- All outputs depend only on registers; there is no combinational path from inputs.
- Request sampled at edge N → first pixel valid in cycle N+1.
- Last pixel in cycle N+SIZE².
- `done` in cycle N+SIZE²+1.
- IDLE in cycle N+SIZE²+2, with a new grant possible at that edge.
- Per-box occupancy is SIZE²+2 cycles.
- Reset asserted mid-operation: immediate return to IDLE, `plot`/`grant` drop asynchronously, and no `done` is issued. The requester must re-request.

## Structure
- Package `vga_pkg`:
  - State typedef/localparams `S_IDLE`, `S_DRAW`, `S_DONE`.
  - `SCREEN_W` = 160, `SCREEN_H` = 120.
  - Colour width 3.
- Sub-module `rr_arb2`:
  - Combinational 2-way round-robin pick from `req` and `last`.
  - Outputs a one-hot `win` and a `win_idx`.
- The pointer register stays in `draw_arbiter`.

## Test plan
- **Single request.** Input: `req` = 01, `x0` = 10, `y0` = 20, `c0` = 3'b100. Expected: 16 plots at (10..13, 20..23) in raster order, all colour 4; `done[0]` pulse at cycle 17 after sampling; `grant` = 01 throughout.
- **Simultaneous requests.** Input: `req` = 11 held through both `done` pulses. Expected: requester 0 served first, then requester 1, then requester 0 again; `grant` never 11; exactly one `busy` gap cycle (IDLE) between boxes.
- **Edge clipping.** Input: `x0` = 158, `y0` = 118, SIZE = 4. Expected: `plot` = 1 only at (158,118), (159,118), (158,119), (159,119); 16 DRAW cycles still elapse; `done` at cycle 17.
- **Input change mid-box.** Input: change `x0`/`c0` during DRAW. Expected: all pixels use the originally latched values.
- **Reset mid-box.** Input: assert `resetn` = 0 at pixel 5. Expected: `plot`/`grant`/`busy` = 0 without waiting for a clock edge; after release with `req` = 10, requester 1 is served from pixel (`x1`, `y1`).
- **SIZE = 1 build.** Input: one request. Expected: one plot; `done` at cycle 2.
